spi_cmd_ctrl: RTL and testbench
===============================

Name: spi_cmd_ctrl

Overview:
- Command/register-access controller between spi_phy and an 8-bit internal register bus.
- Parses each SPI frame from the spi_phy RX stream as: command byte, start-address byte, then payload.
- Write frames become register writes at auto-incrementing addresses.
- Read frames fetch register data and feed it to the spi_phy TX interface under its tx_send_flag/tx_empty handshake.

Parameters:
- ADDR_W, 8, register address width (1..8); the address byte is truncated to its low ADDR_W bits.
- CMD_WR, 8'hF1, write-burst command code.
- CMD_RD, 8'hF2, read-burst command code.
- RD_TIMEOUT, 16, clock cycles to wait for reg_rvld before substituting ERR_BYTE.
- ERR_BYTE, 8'hEE, byte sent on a read timeout.

Ports:
- clock  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_stream_sof  in  1  frame start pulse from spi_phy
- rx_stream_data  in  8  received byte
- rx_stream_vld  in  1  rx_stream_data valid, 1 cycle per byte
- rx_stream_eof  in  1  frame end pulse (cs_n deassert)
- tx_send_flag  in  1  spi_phy is in a read phase and accepts TX bytes
- tx_empty  in  1  spi_phy TX holding register empty
- tx_send_data  out  8  TX byte
- tx_send_valid  out  1  one-cycle TX byte strobe
- tx_send_momment  out  24  count of TX bytes delivered in current frame
- reg_wr  out  1  register write strobe
- reg_rd  out  1  register read request strobe
- reg_addr  out  ADDR_W  register address
- reg_wdata  out  8  write data
- reg_rdata  in  8  read data
- reg_rvld  in  1  reg_rdata valid, 1 cycle, any latency >= 1 after reg_rd
- cmd_err  out  1  one-cycle pulse on unknown command or read timeout
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0, including tx_send_data, reg_addr and tx_send_momment; state IDLE; an in-progress frame is abandoned and nothing else is emitted until the next sof.
- States: IDLE, CMD, ADDR, WRITE, RD_FETCH, RD_WAIT, RD_PUSH, RD_ACK, DRAIN.
- IDLE: on sof -> CMD and clear tx_send_momment. Bytes arriving without a prior sof are ignored.
- CMD: first vld byte.
  - CMD_WR or CMD_RD -> ADDR.
  - Any other value -> pulse cmd_err, go to DRAIN.
- ADDR: next vld byte loads reg_addr.
  - For a write command -> WRITE.
  - For a read command -> RD_FETCH.
- WRITE: each vld byte drives reg_wr=1 for exactly one cycle with reg_wdata=byte and the current reg_addr (registered, 1 cycle after vld). reg_addr then increments, wrapping 2^ADDR_W-1 -> 0.
- RD_FETCH: reg_rd=1 for one cycle at reg_addr -> RD_WAIT.
- RD_WAIT:
  - reg_rvld latches reg_rdata into tx_send_data -> RD_PUSH.
  - If RD_TIMEOUT cycles elapse without reg_rvld: tx_send_data=ERR_BYTE, cmd_err pulse, -> RD_PUSH.
- RD_PUSH: wait for tx_send_flag=1 and tx_empty=1, then tx_send_valid=1 for exactly one cycle -> RD_ACK.
- RD_ACK: wait for tx_empty=0.
  - tx_send_momment increments by 1.
  - reg_addr increments with wrap.
  - -> RD_FETCH (prefetch of the next byte).
- Read frame bytes: bytes received on MOSI during a read frame, after the address byte, are discarded.
- DRAIN: ignore all input until eof -> IDLE.
- eof handling: eof in any non-IDLE state -> IDLE on the next cycle and overrides all other events that cycle.
  - A reg_wr or tx_send_valid scheduled in that same cycle is still issued.
  - A pending reg_rd response arriving after eof is dropped.
- sof while not IDLE (missing eof): treated as eof followed by a new frame; state -> CMD.
- Simultaneous vld and eof: the byte is processed first (e.g. the last write completes), then -> IDLE.
- Short frames: a frame ending after only the command byte, or after the address byte, causes no bus access and no error.
- Latency:
  - reg_wr at most 1 cycle after rx_stream_vld.
  - First reg_rd 1 cycle after the address byte.
  - tx_send_valid at least 1 cycle after reg_rvld.
- busy is registered, high from the cycle after sof until the return to IDLE.

Test Plan:
- Write burst: frame {F1,10,01,02,03,04} -> reg_wr at addresses 0x10..0x13 with data 01..04, no cmd_err, busy low 1 cycle after eof.
- Address wrap, ADDR_W=8: {F1,FE,AA,BB,CC} -> writes FE=AA, FF=BB, 00=CC.
- Read burst: {F2,20}, register model with 2-cycle rvld latency returning addr+1, 8 TX bytes under tx_send_flag -> tx_send_data sequence 21..28, tx_send_momment=8, each tx_send_valid only when tx_empty=1.
- Read timeout: register model never asserts rvld -> after 16 cycles one cmd_err pulse and ERR_BYTE 0xEE sent, next address fetched.
- Bad command: {55,01,02} -> one cmd_err pulse, no reg_wr/reg_rd, IDLE after eof; a following {F1,00,99} writes 00=99.
- Aborts: rst asserted mid write burst and eof mid read (while in RD_WAIT) -> all outputs 0 or IDLE next cycle, late reg_rvld ignored, no tx_send_valid.

Source files
------------

// File: rtl/spi_cmd_ctrl_if.sv
// Bundle of the spi_phy stream/TX handshake and the internal register bus
// seen by spi_cmd_ctrl.
interface spi_cmd_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              rx_stream_sof;
  logic [7:0]        rx_stream_data;
  logic              rx_stream_vld;
  logic              rx_stream_eof;
  logic              tx_send_flag;
  logic              tx_empty;
  logic [7:0]        tx_send_data;
  logic              tx_send_valid;
  logic [23:0]       tx_send_momment;
  logic              reg_wr;
  logic              reg_rd;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic [7:0]        reg_rdata;
  logic              reg_rvld;
  logic              cmd_err;
  logic              busy;

  modport master (
    input  rx_stream_sof, rx_stream_data, rx_stream_vld, rx_stream_eof,
    input  tx_send_flag, tx_empty, reg_rdata, reg_rvld,
    output tx_send_data, tx_send_valid, tx_send_momment,
    output reg_wr, reg_rd, reg_addr, reg_wdata, cmd_err, busy
  );

  modport slave (
    output rx_stream_sof, rx_stream_data, rx_stream_vld, rx_stream_eof,
    output tx_send_flag, tx_empty, reg_rdata, reg_rvld,
    input  tx_send_data, tx_send_valid, tx_send_momment,
    input  reg_wr, reg_rd, reg_addr, reg_wdata, cmd_err, busy
  );
endinterface

// File: rtl/spi_cmd_ctrl.sv
// SPI frame parser: command byte, start address, then a write burst onto the
// register bus or a prefetching read burst fed to the spi_phy TX holding register.
module spi_cmd_ctrl #(
  parameter int         ADDR_W     = 8,
  parameter logic [7:0] CMD_WR     = 8'hF1,
  parameter logic [7:0] CMD_RD     = 8'hF2,
  parameter int         RD_TIMEOUT = 16,
  parameter logic [7:0] ERR_BYTE   = 8'hEE
) (
  input  logic           clock,
  input  logic           rst,
  spi_cmd_ctrl_if.master bus
);
  localparam int TW = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, CMD, ADDR, WRITE, RD_FETCH, RD_WAIT, RD_PUSH, RD_ACK, DRAIN
  } state_t;

  state_t            state_r, state_nxt;
  logic              is_rd_r, is_rd_nxt;
  logic [ADDR_W-1:0] addr_r, addr_nxt;
  logic [7:0]        wdata_r, wdata_nxt;
  logic              wr_r, wr_nxt;
  logic              rd_r;
  logic [7:0]        txd_r, txd_nxt;
  logic              txv_r, txv_nxt;
  logic [23:0]       mom_r, mom_nxt;
  logic              err_r, err_nxt;
  logic              busy_r;
  logic [TW-1:0]     tmo_r, tmo_nxt;

  always_comb begin
    state_nxt = state_r;
    is_rd_nxt = is_rd_r;
    // Post-increment after every issued write, so back-to-back bytes still advance.
    addr_nxt  = wr_r ? addr_r + 1'b1 : addr_r;
    wdata_nxt = wdata_r;
    wr_nxt    = 1'b0;
    txd_nxt   = txd_r;
    txv_nxt   = 1'b0;
    mom_nxt   = mom_r;
    err_nxt   = 1'b0;
    tmo_nxt   = tmo_r;

    case (state_r)
      IDLE: ;
      CMD: if (bus.rx_stream_vld) begin
        if (bus.rx_stream_data == CMD_WR || bus.rx_stream_data == CMD_RD) begin
          is_rd_nxt = (bus.rx_stream_data == CMD_RD);
          state_nxt = ADDR;
        end else begin
          err_nxt   = 1'b1;
          state_nxt = DRAIN;
        end
      end
      ADDR: if (bus.rx_stream_vld) begin
        addr_nxt  = bus.rx_stream_data[ADDR_W-1:0];
        state_nxt = is_rd_r ? RD_FETCH : WRITE;
      end
      WRITE: if (bus.rx_stream_vld) begin
        wr_nxt    = 1'b1;
        wdata_nxt = bus.rx_stream_data;
      end
      RD_FETCH: begin
        tmo_nxt   = '0;
        state_nxt = RD_WAIT;
      end
      // A read response racing with eof is dropped, along with the timeout.
      RD_WAIT: if (!bus.rx_stream_eof) begin
        if (bus.reg_rvld) begin
          txd_nxt   = bus.reg_rdata;
          state_nxt = RD_PUSH;
        end else if (tmo_r == TW'(RD_TIMEOUT - 1)) begin
          txd_nxt   = ERR_BYTE;
          err_nxt   = 1'b1;
          state_nxt = RD_PUSH;
        end else begin
          tmo_nxt = tmo_r + 1'b1;
        end
      end
      RD_PUSH: if (bus.tx_send_flag && bus.tx_empty) begin
        txv_nxt   = 1'b1;
        state_nxt = RD_ACK;
      end
      RD_ACK: if (!bus.rx_stream_eof && !bus.tx_empty) begin
        mom_nxt   = mom_r + 24'd1;
        addr_nxt  = addr_r + 1'b1;
        state_nxt = RD_FETCH;
      end
      DRAIN: ;
      default: state_nxt = IDLE;
    endcase

    if (state_r != IDLE && bus.rx_stream_eof) state_nxt = IDLE;
    // A fresh sof always restarts framing, even without a preceding eof.
    if (bus.rx_stream_sof) begin
      state_nxt = CMD;
      mom_nxt   = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_r <= IDLE;
      is_rd_r <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      wr_r    <= 1'b0;
      rd_r    <= 1'b0;
      txd_r   <= '0;
      txv_r   <= 1'b0;
      mom_r   <= '0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
      tmo_r   <= '0;
    end else begin
      state_r <= state_nxt;
      is_rd_r <= is_rd_nxt;
      addr_r  <= addr_nxt;
      wdata_r <= wdata_nxt;
      wr_r    <= wr_nxt;
      rd_r    <= (state_nxt == RD_FETCH);
      txd_r   <= txd_nxt;
      txv_r   <= txv_nxt;
      mom_r   <= mom_nxt;
      err_r   <= err_nxt;
      busy_r  <= (state_nxt != IDLE);
      tmo_r   <= tmo_nxt;
    end
  end

  assign bus.reg_addr        = addr_r;
  assign bus.reg_wdata       = wdata_r;
  assign bus.reg_wr          = wr_r;
  assign bus.reg_rd          = rd_r;
  assign bus.tx_send_data    = txd_r;
  assign bus.tx_send_valid   = txv_r;
  assign bus.tx_send_momment = mom_r;
  assign bus.cmd_err         = err_r;
  assign bus.busy            = busy_r;
endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed bench for spi_cmd_ctrl with a behavioural register file and
// spi_phy TX holding-register model.
module tb_spi_cmd_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_cmd_ctrl_if #(.ADDR_W(8)) bus();

  spi_cmd_ctrl #(
    .ADDR_W(8), .CMD_WR(8'hF1), .CMD_RD(8'hF2), .RD_TIMEOUT(16), .ERR_BYTE(8'hEE)
  ) dut (
    .clock(clk),
    .rst  (rst),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] wr_addr[$];
  logic [7:0] wr_data[$];
  logic [7:0] rd_addr[$];
  int         rd_cyc[$];
  logic [7:0] tx_log[$];
  logic [7:0] fq[$];
  int err_cnt = 0, txv_bad = 0, cyc_n = 0, err_cyc = 0;
  int rd_lat = 2, rd_pend = 0, tx_limit = 0, empty_hold = 0;
  bit rd_dead = 1'b0;
  logic [7:0] rd_paddr = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Register file (returns addr+1 after rd_lat cycles) and spi_phy TX model.
  always @(negedge clk) begin
    cyc_n++;
    if (bus.reg_wr) begin
      wr_addr.push_back(bus.reg_addr);
      wr_data.push_back(bus.reg_wdata);
    end
    if (bus.cmd_err) begin
      err_cnt++;
      err_cyc = cyc_n;
    end
    if (bus.tx_send_valid) begin
      if (!bus.tx_empty) txv_bad++;
      tx_log.push_back(bus.tx_send_data);
      bus.tx_empty = 1'b0;
      empty_hold   = 3;
    end else if (empty_hold > 0) begin
      empty_hold--;
      if (empty_hold == 0) bus.tx_empty = 1'b1;
    end
    bus.tx_send_flag = (tx_log.size() < tx_limit);
    bus.reg_rvld = 1'b0;
    if (rd_pend > 0) begin
      rd_pend--;
      if (rd_pend == 0) begin
        bus.reg_rvld  = 1'b1;
        bus.reg_rdata = rd_paddr + 8'd1;
      end
    end
    if (bus.reg_rd) begin
      rd_addr.push_back(bus.reg_addr);
      rd_cyc.push_back(cyc_n);
      if (!rd_dead) begin
        rd_pend  = rd_lat;
        rd_paddr = bus.reg_addr;
      end
    end
  end

  task automatic cyc(input bit s, input bit v, input logic [7:0] d, input bit e);
    bus.rx_stream_sof  = s;
    bus.rx_stream_vld  = v;
    bus.rx_stream_data = d;
    bus.rx_stream_eof  = e;
    @(posedge clk);
    #1;
    bus.rx_stream_sof = 1'b0;
    bus.rx_stream_vld = 1'b0;
    bus.rx_stream_eof = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends fq as one frame; optionally the last byte shares its cycle with eof.
  task automatic frame(input bit eof_on_last);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < fq.size(); i++) begin
      if (eof_on_last && i == fq.size() - 1) begin
        cyc(1'b0, 1'b1, fq[i], 1'b1);
      end else begin
        cyc(1'b0, 1'b1, fq[i], 1'b0);
        idle(2);
      end
    end
    if (!eof_on_last) cyc(1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    rd_addr.delete();
    rd_cyc.delete();
    tx_log.delete();
    err_cnt = 0;
    txv_bad = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_stream_sof  = 1'b0;
    bus.rx_stream_vld  = 1'b0;
    bus.rx_stream_data = 8'h00;
    bus.rx_stream_eof  = 1'b0;
    bus.tx_send_flag   = 1'b0;
    bus.tx_empty       = 1'b1;
    bus.reg_rdata      = 8'h00;
    bus.reg_rvld       = 1'b0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_reg_wr", bus.reg_wr, 0);
    check("rst_reg_rd", bus.reg_rd, 0);
    check("rst_reg_addr", bus.reg_addr, 0);
    check("rst_reg_wdata", bus.reg_wdata, 0);
    check("rst_tx_data", bus.tx_send_data, 0);
    check("rst_tx_valid", bus.tx_send_valid, 0);
    check("rst_momment", bus.tx_send_momment, 0);
    check("rst_cmd_err", bus.cmd_err, 0);
    check("rst_busy", bus.busy, 0);
    rst = 1'b0;
    idle(2);

    // Write burst with per-byte latency checks
    clear_log();
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    check("wr_busy_sof", bus.busy, 1);
    cyc(1'b0, 1'b1, 8'hF1, 1'b0);
    cyc(1'b0, 1'b1, 8'h10, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 8'(i + 1), 1'b0);
      check("wr_strobe", bus.reg_wr, 1);
      check("wr_addr", bus.reg_addr, 32'h10 + i);
      check("wr_data", bus.reg_wdata, i + 1);
      idle(1);
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    check("wr_busy_eof", bus.busy, 0);
    idle(2);
    check("wr_count", wr_addr.size(), 4);
    check("wr_no_err", err_cnt, 0);

    // Address wrap, last byte arriving together with eof
    clear_log();
    fq = {8'hF1, 8'hFE, 8'hAA, 8'hBB, 8'hCC};
    frame(1'b1);
    idle(2);
    check("wrap_count", wr_addr.size(), 3);
    if (wr_addr.size() == 3) begin
      check("wrap_a0", wr_addr[0], 8'hFE);
      check("wrap_d0", wr_data[0], 8'hAA);
      check("wrap_a1", wr_addr[1], 8'hFF);
      check("wrap_d1", wr_data[1], 8'hBB);
      check("wrap_a2", wr_addr[2], 8'h00);
      check("wrap_d2", wr_data[2], 8'hCC);
    end
    check("wrap_busy", bus.busy, 0);

    // Read burst of 8 bytes from 0x20
    clear_log();
    rd_lat   = 2;
    tx_limit = 8;
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'hF2, 1'b0);
    cyc(1'b0, 1'b1, 8'h20, 1'b0);
    check("rd_first_strobe", bus.reg_rd, 1);
    check("rd_first_addr", bus.reg_addr, 8'h20);
    for (int k = 0; k < 400 && tx_log.size() < 8; k++) idle(1);
    idle(10);
    check("rd_tx_count", tx_log.size(), 8);
    for (int i = 0; i < tx_log.size(); i++) check("rd_tx_byte", tx_log[i], 32'h21 + i);
    check("rd_momment", bus.tx_send_momment, 8);
    check("rd_valid_when_empty", txv_bad, 0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    check("rd_busy_eof", bus.busy, 0);
    check("rd_no_err", err_cnt, 0);
    check("rd_no_wr", wr_addr.size(), 0);
    tx_limit = 0;
    idle(8);

    // Read timeout substitutes the error byte and moves on
    clear_log();
    rd_dead  = 1'b1;
    tx_limit = 1;
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'hF2, 1'b0);
    cyc(1'b0, 1'b1, 8'h40, 1'b0);
    for (int k = 0; k < 100 && tx_log.size() < 1; k++) idle(1);
    idle(5);
    check("tmo_tx_count", tx_log.size(), 1);
    if (tx_log.size() > 0) check("tmo_err_byte", tx_log[0], 8'hEE);
    check("tmo_err_pulses", err_cnt, 1);
    if (rd_cyc.size() > 0) check("tmo_latency", err_cyc - rd_cyc[0], 17);
    check("tmo_refetch", rd_addr.size(), 2);
    if (rd_addr.size() > 1) check("tmo_next_addr", rd_addr[1], 8'h41);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    rd_dead  = 1'b0;
    tx_limit = 0;
    idle(4);

    // Unknown command, then a good write frame
    clear_log();
    fq = {8'h55, 8'h01, 8'h02};
    frame(1'b0);
    idle(2);
    check("bad_err_pulses", err_cnt, 1);
    check("bad_no_wr", wr_addr.size(), 0);
    check("bad_no_rd", rd_addr.size(), 0);
    check("bad_busy", bus.busy, 0);
    fq = {8'hF1, 8'h00, 8'h99};
    frame(1'b0);
    idle(2);
    check("post_bad_count", wr_addr.size(), 1);
    if (wr_addr.size() == 1) begin
      check("post_bad_addr", wr_addr[0], 8'h00);
      check("post_bad_data", wr_data[0], 8'h99);
    end

    // Reset in the middle of a write burst; trailing bytes without sof ignored
    clear_log();
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'hF1, 1'b0);
    cyc(1'b0, 1'b1, 8'h30, 1'b0);
    cyc(1'b0, 1'b1, 8'h11, 1'b0);
    idle(1);
    rst = 1'b1;
    cyc(1'b0, 1'b1, 8'h22, 1'b0);
    check("rstmid_wr", bus.reg_wr, 0);
    check("rstmid_busy", bus.busy, 0);
    check("rstmid_addr", bus.reg_addr, 0);
    check("rstmid_wdata", bus.reg_wdata, 0);
    rst = 1'b0;
    cyc(1'b0, 1'b1, 8'h33, 1'b0);
    idle(2);
    check("rstmid_wr_count", wr_addr.size(), 1);

    // eof while waiting for a slow read response
    clear_log();
    rd_lat   = 6;
    tx_limit = 8;
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'hF2, 1'b0);
    cyc(1'b0, 1'b1, 8'h50, 1'b0);
    idle(2);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    check("eofrd_busy", bus.busy, 0);
    idle(12);
    check("eofrd_no_tx", tx_log.size(), 0);
    check("eofrd_no_err", err_cnt, 0);
    check("eofrd_one_rd", rd_addr.size(), 1);
    rd_lat   = 2;
    tx_limit = 0;

    // Short frames cause no bus traffic
    clear_log();
    fq = {8'hF1, 8'h60};
    frame(1'b0);
    fq = {8'hF2, 8'h61};
    frame(1'b1);
    idle(4);
    check("short_no_wr", wr_addr.size(), 0);
    check("short_no_rd", rd_addr.size(), 0);
    check("short_no_err", err_cnt, 0);

    // sof without eof restarts the frame
    clear_log();
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'hF1, 1'b0);
    cyc(1'b0, 1'b1, 8'h70, 1'b0);
    cyc(1'b0, 1'b1, 8'h5A, 1'b0);
    idle(1);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'hF1, 1'b0);
    cyc(1'b0, 1'b1, 8'h80, 1'b0);
    cyc(1'b0, 1'b1, 8'h7B, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    idle(2);
    check("resof_count", wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      check("resof_a0", wr_addr[0], 8'h70);
      check("resof_a1", wr_addr[1], 8'h80);
      check("resof_d1", wr_data[1], 8'h7B);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
